reg_file_sb: RTL and testbench

//   Parametrised integer register file with multiple read ports and one write port.

---
 rtl/soin_rv_pkg.sv | 14 +
 rtl/reg_file_rd_port.sv | 40 ++++
 rtl/reg_file_sb.sv | 93 +++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/soin_rv_pkg.sv
// Shared SOIN-RV core constants: default register-file geometry and address width.
package soin_rv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Index width for a register file of nregs entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned AW_DEF = addr_width(NREGS_DEF);

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: storage lookup with hardwired-zero,
// write-through bypass and busy (RAW hazard) reporting.
module reg_file_rd_port
  import soin_rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = addr_width(NREGS),
  parameter int unsigned BYPASS = 1,
  parameter int unsigned ZERO_R = 1
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREGS-1:0][XLEN-1:0]   regs,
  input  logic [NREGS-1:0]             busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  output logic [XLEN-1:0]              data,
  output logic                         hazard
);

  logic zero_hit;
  logic byp_hit;

  // Select hardwired zero, bypassed write data, or stored value.
  always_comb begin
    zero_hit = (ZERO_R != 0) && (addr == '0);
    byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr) && !zero_hit;
    data     = regs[addr];
    hazard   = busy[addr];
    if (zero_hit) begin
      data   = '0;
      hazard = 1'b0;
    end else if (byp_hit) begin
      data   = wr_data;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD read ports, one write port, optional
// write-through bypass and a per-register busy scoreboard for RAW detection.
module reg_file_sb
  import soin_rv_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned BYPASS = 1,
  parameter  int unsigned ZERO_R = 1,
  localparam int unsigned AW     = addr_width(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic                       wr_drop;
  logic                       wr_live;

  // Writes to the hardwired zero register are discarded.
  always_comb begin
    wr_drop = (ZERO_R != 0) && (wr_addr == '0);
    // A write presented during reset never lands, so it must not bypass either;
    // this keeps every read at zero while rst is high.
    wr_live = wr_en && !rst;
  end

  // Storage array update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_en && !wr_drop) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Next scoreboard: flush dominates; otherwise clear-on-write then
  // set-on-issue, so a coincident issue to the written register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en) busy_nxt[wr_addr] = 1'b0;
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
    end
    if (ZERO_R != 0) busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_file_rd_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .AW     (AW),
      .BYPASS (BYPASS),
      .ZERO_R (ZERO_R)
    ) u_rd (
      .addr    (rd_addr[i*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .wr_en   (wr_live),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[i*XLEN +: XLEN]),
      .hazard  (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build, a no-bypass/ordinary-x0
// build sharing its stimulus, and a 64-bit, 16-entry, 3-port build.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default build (BYPASS=1, ZERO_R=1) and no-bypass build share stimulus.
  logic [9:0]  a_rd_addr = '0;
  logic        a_wr_en   = 1'b0;
  logic [4:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_iss_en  = 1'b0;
  logic [4:0]  a_iss_addr = '0;
  logic        a_flush   = 1'b0;
  logic [63:0] a_rd_data, n_rd_data;
  logic [1:0]  a_rd_busy, n_rd_busy;
  logic [31:0] a_busy_vec, n_busy_vec;

  // Wide build.
  logic [11:0]  w_rd_addr  = '0;
  logic         w_wr_en    = 1'b0;
  logic [3:0]   w_wr_addr  = '0;
  logic [63:0]  w_wr_data  = '0;
  logic         w_iss_en   = 1'b0;
  logic [3:0]   w_iss_addr = '0;
  logic         w_flush    = 1'b0;
  logic [191:0] w_rd_data;
  logic [2:0]   w_rd_busy;
  logic [15:0]  w_busy_vec;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_R(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .flush(a_flush), .busy_vec(a_busy_vec)
  );

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_R(0)) u_n (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .flush(a_flush), .busy_vec(n_busy_vec)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1), .ZERO_R(1)) u_w (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .iss_en(w_iss_en), .iss_addr(w_iss_addr), .flush(w_flush), .busy_vec(w_busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en  = 1'b0;
    a_iss_en = 1'b0;
    a_flush  = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #7;
    check("rst_busy_vec", a_busy_vec, 64'h0);
    check("rst_rd0", a_rd_data[31:0], 64'h0);
    check("rst_rd_busy", a_rd_busy, 64'h0);
    #3 rst = 1'b0;

    // 1) Write x5, issue x6, then reset mid-cycle with a pending write
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    a_iss_en = 1'b1; a_iss_addr = 5'd6;
    step();
    idle();
    a_rd_addr = {5'd6, 5'd5};
    #1;
    check("t1_rd_x5", a_rd_data[31:0], 64'hDEADBEEF);
    check("t1_rd_busy", a_rd_busy, 64'h2);
    check("t1_busy_vec", a_busy_vec, 64'h40);
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h55;
    #1 rst = 1'b1;
    #1;
    check("t1_rst_rd_x5", a_rd_data[31:0], 64'h0);
    check("t1_rst_busy_vec", a_busy_vec, 64'h0);
    check("t1_rst_rd_busy", a_rd_busy, 64'h0);
    check("t1_rst_nb_rd_x5", n_rd_data[31:0], 64'h0);
    #8;
    rst = 1'b0;
    idle();
    #1;
    check("t1_post_rst_rd_x5", a_rd_data[31:0], 64'h0);

    // 2) Zero register: write and issue x0
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h12345678;
    a_iss_en = 1'b1; a_iss_addr = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    check("t2_bypass_x0", a_rd_data[31:0], 64'h0);
    step();
    idle();
    #1;
    check("t2_rd_x0", a_rd_data[31:0], 64'h0);
    check("t2_rd_busy_x0", a_rd_busy, 64'h0);
    check("t2_busy_vec", a_busy_vec, 64'h0);
    check("t2_nb_rd_x0", n_rd_data[31:0], 64'h12345678);
    check("t2_nb_busy_vec", n_busy_vec, 64'h1);
    check("t2_nb_rd_busy", n_rd_busy, 64'h3);

    // 3) Bypass: x7=0x11, issue x7, then write 0x22 while reading x7
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h11;
    step();
    idle();
    a_iss_en = 1'b1; a_iss_addr = 5'd7;
    step();
    idle();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h22;
    a_rd_addr = {5'd7, 5'd7};
    #1;
    check("t3_byp_rd", a_rd_data[31:0], 64'h22);
    check("t3_byp_busy", a_rd_busy, 64'h0);
    check("t3_nb_rd", n_rd_data[31:0], 64'h11);
    check("t3_nb_busy", n_rd_busy, 64'h3);
    step();
    idle();
    #1;
    check("t3_nb_rd_next", n_rd_data[31:0], 64'h22);
    check("t3_nb_busy_next", n_rd_busy, 64'h0);
    check("t3_busy_vec", a_busy_vec, 64'h0);

    // 4) Scoreboard: issue x3, then write it back
    a_iss_en = 1'b1; a_iss_addr = 5'd3;
    a_rd_addr = {5'd3, 5'd3};
    step();
    idle();
    #1;
    check("t4_busy_vec_set", a_busy_vec, 64'h8);
    check("t4_rd_busy_set", a_rd_busy, 64'h3);
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hA5;
    step();
    idle();
    #1;
    check("t4_busy_vec_clr", a_busy_vec, 64'h0);
    check("t4_rd_x3", a_rd_data[63:32], 64'hA5);

    // 5) Same-cycle issue+write to x9, then flush with issue x4
    a_iss_en = 1'b1; a_iss_addr = 5'd9;
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
    a_rd_addr = {5'd9, 5'd9};
    #1;
    check("t5_byp_rd_x9", a_rd_data[31:0], 64'h99);
    check("t5_byp_busy_x9", a_rd_busy, 64'h0);
    step();
    idle();
    #1;
    check("t5_busy_vec_x9", a_busy_vec, 64'h200);
    check("t5_rd_x9_p0", a_rd_data[31:0], 64'h99);
    check("t5_rd_x9_p1", a_rd_data[63:32], 64'h99);
    check("t5_rd_busy_x9", a_rd_busy, 64'h3);
    a_flush = 1'b1;
    a_iss_en = 1'b1; a_iss_addr = 5'd4;
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h1010;
    a_rd_addr = {5'd10, 5'd4};
    step();
    idle();
    #1;
    check("t5_flush_busy_vec", a_busy_vec, 64'h0);
    check("t5_flush_wr_x10", a_rd_data[63:32], 64'h1010);
    check("t5_flush_rd_busy", a_rd_busy, 64'h0);

    // 6) Wide build: all three ports read x15
    w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 64'hFFFF_0000_FFFF_0000;
    w_rd_addr = {4'd15, 4'd15, 4'd15};
    step();
    w_wr_en = 1'b0;
    #1;
    check("t6_p0", w_rd_data[63:0], 64'hFFFF_0000_FFFF_0000);
    check("t6_p1", w_rd_data[127:64], 64'hFFFF_0000_FFFF_0000);
    check("t6_p2", w_rd_data[191:128], 64'hFFFF_0000_FFFF_0000);
    check("t6_busy_vec", w_busy_vec, 64'h0);
    w_rd_addr = {4'd0, 4'd15, 4'd2};
    #1;
    check("t6_p0_x2", w_rd_data[63:0], 64'h0);
    check("t6_p2_x0", w_rd_data[191:128], 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
